// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotator pipeline.
// Holds the atan table, the datapath widths and the per-stage state bundle.
package cordic_pkg;

    localparam int PHASE_W     = 22;
    localparam int DATA_W      = 24;
    localparam int N_ITER      = 16;
    localparam int K14_DEFAULT = 16468;

    typedef logic signed [DATA_W-1:0]  data_t;
    typedef logic signed [PHASE_W-1:0] phase_t;

    // round(atan(2^-i) * 2^21 / pi); phase LSB is pi/2^21 rad
    localparam phase_t ATAN_TABLE [N_ITER] = '{
        22'sd524288, 22'sd309506, 22'sd163534, 22'sd83012,
        22'sd41667,  22'sd20854,  22'sd10430,  22'sd5215,
        22'sd2608,   22'sd1304,   22'sd652,    22'sd326,
        22'sd163,    22'sd81,     22'sd41,     22'sd20
    };

    typedef struct packed {
        data_t      x;
        data_t      y;
        phase_t     z;
        logic [1:0] q;
    } stage_t;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: rotates (x, y) by +/-atan(2^-Shift)
// toward driving the residual angle z to zero; the quadrant tag rides along.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned Shift = 0,
    parameter phase_t      Angle = '0
) (
    input  logic   clk,
    input  logic   aresetn,
    input  stage_t stage_in,
    output stage_t stage_out
);

    data_t  x_in;
    data_t  y_in;
    phase_t z_in;
    data_t  x_shr;
    data_t  y_shr;
    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        // Unpack into signed locals so >>> is guaranteed arithmetic
        x_in    = stage_in.x;
        y_in    = stage_in.y;
        z_in    = stage_in.z;
        x_shr   = x_in >>> Shift;
        y_shr   = y_in >>> Shift;
        stage_d = stage_in;
        if (!z_in[PHASE_W-1]) begin
            stage_d.x = x_in - y_shr;
            stage_d.y = y_in + x_shr;
            stage_d.z = z_in - Angle;
        end else begin
            stage_d.x = x_in + y_shr;
            stage_d.y = y_in - x_shr;
            stage_d.z = z_in + Angle;
        end
    end

    // aresetn is active-high here despite its name
    always_ff @(posedge clk) begin
        if (aresetn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_out = stage_q;

endmodule

// File: rtl/cordic_iterate_unit.sv
// Fully pipelined 16-iteration rotation-mode CORDIC: first-quadrant phase in,
// scaled cos/sin out 17 register stages later, quadrant tag aligned alongside.
module cordic_iterate_unit
    import cordic_pkg::*;
#(
    parameter int k14 = K14_DEFAULT
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic signed [PHASE_W-1:0] phase_pre,
    input  logic [1:0]                quadrant_flag,
    output logic [1:0]                quadrant,
    output logic signed [DATA_W-1:0]  cos_pre,
    output logic signed [DATA_W-1:0]  sin_pre
);

    localparam data_t K14_X = data_t'(k14);

    stage_t load_d;
    stage_t load_q;
    stage_t pipe [N_ITER+1];

    always_comb begin
        load_d   = '0;
        load_d.x = K14_X;
        load_d.y = '0;
        load_d.z = phase_pre;
        load_d.q = quadrant_flag;
    end

    // Stage 0: load register; reset zeroes it like every other stage
    always_ff @(posedge clk) begin
        if (aresetn) begin
            load_q <= '0;
        end else begin
            load_q <= load_d;
        end
    end

    assign pipe[0] = load_q;

    for (genvar i = 0; i < N_ITER; i++) begin : g_stage
        cordic_stage #(
            .Shift(i),
            .Angle(ATAN_TABLE[i])
        ) u_stage (
            .clk      (clk),
            .aresetn  (aresetn),
            .stage_in (pipe[i]),
            .stage_out(pipe[i+1])
        );
    end

    assign cos_pre  = pipe[N_ITER].x;
    assign sin_pre  = pipe[N_ITER].y;
    assign quadrant = pipe[N_ITER].q;

endmodule

// File: tb/tb_cordic_iterate_unit.sv
// Self-checking bench for cordic_iterate_unit: random and directed phases,
// compared per clock against a history-based reference of the rotator.
module tb_cordic_iterate_unit;

    localparam int  K14      = 16468;
    localparam int  Lat      = 16;    // edges after the sampling edge (17th edge counting it)
    localparam int  MaxEdges = 1024;
    localparam real Pi       = 3.14159265358979;

    logic               clk = 1'b0;
    logic               aresetn;
    logic signed [21:0] phase_pre;
    logic [1:0]         quadrant_flag;
    logic [1:0]         quadrant;
    logic signed [23:0] cos_pre;
    logic signed [23:0] sin_pre;

    int n_checks = 0;
    int n_errors = 0;
    int n_edge   = 0;
    int atan_tbl [16];
    bit h_rst [MaxEdges];
    int h_ph  [MaxEdges];
    int h_fl  [MaxEdges];

    always #5 clk = ~clk;

    cordic_iterate_unit #(
        .k14(K14)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .phase_pre    (phase_pre),
        .quadrant_flag(quadrant_flag),
        .quadrant     (quadrant),
        .cos_pre      (cos_pre),
        .sin_pre      (sin_pre)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", tag, n_edge, got, exp);
        end
    endtask

    // Plain integer CORDIC from the iteration rules, angles from $atan
    function automatic void cordic_ref(input int ph, output int xc, output int ys);
        int x;
        int y;
        int z;
        int xn;
        x = K14;
        y = 0;
        z = ph;
        for (int i = 0; i < 16; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_tbl[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_tbl[i];
            end
            x = xn;
        end
        xc = x;
        ys = y;
    endfunction

    task automatic check_named(input int ph, input int c, input int s);
        int ec;
        int es;
        int ok;
        bit hit;
        hit = 1'b1;
        case (ph)
            0:       begin ec = 27119; es = 0;     end
            280000:  begin ec = 24768; es = 11045; end
            524288:  begin ec = 19176; es = 19176; end
            1048576: begin ec = 0;     es = 27119; end
            default: begin ec = 0;     es = 0;     hit = 1'b0; end
        endcase
        if (hit) begin
            ok = ((c - ec) <= 4 && (c - ec) >= -4) ? 1 : 0;
            check_eq("cos_tol", ok, 1);
            ok = ((s - es) <= 4 && (s - es) >= -4) ? 1 : 0;
            check_eq("sin_tol", ok, 1);
        end
    endtask

    task automatic step(input bit rst, input int ph, input int fl);
        int  s;
        bit  zero;
        int  ec;
        int  es;
        int  eq;
        aresetn       = rst;
        phase_pre     = ph[21:0];
        quadrant_flag = fl[1:0];
        @(posedge clk);
        h_rst[n_edge] = rst;
        h_ph[n_edge]  = ph;
        h_fl[n_edge]  = fl;
        #1;
        s    = n_edge - Lat;
        zero = (s < 0);
        if (!zero) begin
            for (int k = s; k <= n_edge; k++) begin
                if (h_rst[k]) zero = 1'b1;
            end
        end
        if (zero) begin
            ec = 0;
            es = 0;
            eq = 0;
        end else begin
            cordic_ref(h_ph[s], ec, es);
            eq = h_fl[s];
        end
        check_eq("cos_pre", cos_pre, ec);
        check_eq("sin_pre", sin_pre, es);
        check_eq("quadrant", quadrant, eq);
        if (!zero) check_named(h_ph[s], cos_pre, sin_pre);
        n_edge++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            atan_tbl[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 2097152.0 / Pi + 0.5);
        end

        // Reset, then zero phase through release and beyond the latency
        step(1'b1, 0, 0);
        step(1'b1, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 0);

        // Held mid-quadrant and boundary phases
        for (int i = 0; i < 20; i++) step(1'b0, 280000, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 524288, 1);
        for (int i = 0; i < 20; i++) step(1'b0, 1048576, 2);

        // Back-to-back stream with distinct tags
        step(1'b0, 0, 0);
        step(1'b0, 262144, 1);
        step(1'b0, 524288, 2);
        step(1'b0, 786432, 3);

        // Random phases across the valid range
        for (int i = 0; i < 150; i++) begin
            step(1'b0, int'($urandom_range(0, 1048576)), int'($urandom_range(0, 3)));
        end

        // Reset with samples in flight, then resume
        for (int i = 0; i < 10; i++) begin
            step(1'b0, int'($urandom_range(0, 1048576)), int'($urandom_range(0, 3)));
        end
        step(1'b1, int'($urandom_range(0, 1048576)), int'($urandom_range(0, 3)));
        for (int i = 0; i < 40; i++) begin
            step(1'b0, int'($urandom_range(0, 1048576)), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 18; i++) step(1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
